// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data BRAM (2K x 16 by default) between three
// requesters:
//   * CPU mem/wb stage   - no stall path, so it always owns the BRAM on any
//                          cycle where it issues a load or a store.
//   * accelerator port   - req/gnt handshake, reads or writes.
//   * CCD/IPU capture    - req/gnt handshake, writes only.
// The accelerator and CCD ports share the cycles the CPU leaves idle using a
// 1-bit round-robin pointer. A saturating wait counter watches the CCD port
// and raises a sticky overrun flag when pixels are being held off too long.
//
// Handshake (acc and ccd ports): the requester raises req together with a
// stable address/data and keeps all of them stable until it sees gnt high
// in the same cycle. The access happens in the cycle gnt is high (grant
// logic is combinational, so there is zero grant latency). Dropping req
// before gnt cancels the request with no side effects. A requester may
// keep req high after a grant to issue back-to-back accesses.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_ren/cpu_wren/cpu_addr/
//   cpu_wdata/cpu_rdata            CPU port; rdata is raw BRAM output
//   acc_req/acc_we/acc_addr/
//   acc_wdata/acc_gnt/acc_rvalid/
//   acc_rdata                      accelerator req/gnt port + read return
//   ccd_req/ccd_addr/ccd_wdata/
//   ccd_gnt                        CCD pixel write req/gnt port
//   ccd_overrun, overrun_clr       sticky starvation flag and its clear
//   bram_en/bram_we/bram_addr/
//   bram_wdata/bram_rdata          BRAM interface (1-cycle read latency)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 16,
    parameter int CCD_MAX_WAIT = 8,
    parameter int WAIT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    // CPU port
    input  logic              cpu_ren,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,

    // Accelerator port
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    output logic [DATA_W-1:0] acc_rdata,

    // CCD pixel-capture port
    input  logic              ccd_req,
    input  logic [ADDR_W-1:0] ccd_addr,
    input  logic [DATA_W-1:0] ccd_wdata,
    output logic              ccd_gnt,
    output logic              ccd_overrun,
    input  logic              overrun_clr,

    // BRAM port
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    // Round-robin pointer: which secondary port won the most recent grant.
    typedef enum logic {
        LW_ACC = 1'b0,
        LW_CCD = 1'b1
    } winner_e;

    // The overrun flag fires on the increment that lands exactly on
    // CCD_MAX_WAIT, i.e. when the counter currently holds CCD_MAX_WAIT-1.
    localparam logic [WAIT_W-1:0] WAIT_PRE_MAX = WAIT_W'(CCD_MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT     = {WAIT_W{1'b1}};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    winner_e           last_winner_q, last_winner_d;
    logic              acc_rvalid_q,  acc_rvalid_d;
    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic              ccd_overrun_q, ccd_overrun_d;

    // -----------------------------------------------------------------------
    // Grant decision
    // -----------------------------------------------------------------------
    logic cpu_sel;
    logic acc_sel;
    logic ccd_sel;

    always_comb begin
        cpu_sel = cpu_ren | cpu_wren;
        acc_sel = 1'b0;
        ccd_sel = 1'b0;
        if (!cpu_sel) begin
            if (acc_req && ccd_req) begin
                // Contention: hand the slot to whoever did not win last.
                if (last_winner_q == LW_CCD) begin
                    acc_sel = 1'b1;
                end else begin
                    ccd_sel = 1'b1;
                end
            end else begin
                acc_sel = acc_req;
                ccd_sel = ccd_req;
            end
        end
    end

    assign acc_gnt = acc_sel;
    assign ccd_gnt = ccd_sel;

    // -----------------------------------------------------------------------
    // BRAM request mux; an idle cycle drives all-zero so nothing stray
    // reaches the BRAM pins.
    // -----------------------------------------------------------------------
    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        if (cpu_sel) begin
            // A simultaneous load+store is treated as a store.
            bram_en    = 1'b1;
            bram_we    = cpu_wren;
            bram_addr  = cpu_addr;
            bram_wdata = cpu_wdata;
        end else if (acc_sel) begin
            bram_en    = 1'b1;
            bram_we    = acc_we;
            bram_addr  = acc_addr;
            bram_wdata = acc_wdata;
        end else if (ccd_sel) begin
            bram_en    = 1'b1;
            bram_we    = 1'b1;
            bram_addr  = ccd_addr;
            bram_wdata = ccd_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read return paths
    // -----------------------------------------------------------------------
    // The CPU tracks its own load latency, so it sees the raw BRAM output.
    assign cpu_rdata = bram_rdata;

    // acc_rdata is zero outside a valid beat so stale BRAM data never leaks
    // into the accelerator datapath.
    assign acc_rvalid = acc_rvalid_q;
    assign acc_rdata  = acc_rvalid_q ? bram_rdata : '0;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic ccd_denied;
    logic overrun_set;

    always_comb begin
        // Pointer only moves when a secondary port actually gets the slot,
        // so cancelled or CPU-blocked requests leave it untouched.
        last_winner_d = last_winner_q;
        if (acc_sel) begin
            last_winner_d = LW_ACC;
        end else if (ccd_sel) begin
            last_winner_d = LW_CCD;
        end

        acc_rvalid_d = acc_sel & ~acc_we;

        // Starvation counter: runs only while the CCD is waiting.
        ccd_denied  = ccd_req & ~ccd_sel;
        overrun_set = 1'b0;
        wait_cnt_d  = '0;
        if (ccd_denied) begin
            if (wait_cnt_q != WAIT_SAT) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
            overrun_set = (wait_cnt_q == WAIT_PRE_MAX);
        end

        // Set beats clear so a new overrun is never lost to a racing clear.
        ccd_overrun_d = ccd_overrun_q;
        if (overrun_set) begin
            ccd_overrun_d = 1'b1;
        end else if (overrun_clr) begin
            ccd_overrun_d = 1'b0;
        end
    end

    assign ccd_overrun = ccd_overrun_q;

    // -----------------------------------------------------------------------
    // Registers. Reset points the round-robin at CCD so the accelerator is
    // favoured on the first contended cycle; any read return in flight is
    // dropped.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner_q <= LW_CCD;
            acc_rvalid_q  <= 1'b0;
            wait_cnt_q    <= '0;
            ccd_overrun_q <= 1'b0;
        end else begin
            last_winner_q <= last_winner_d;
            acc_rvalid_q  <= acc_rvalid_d;
            wait_cnt_q    <= wait_cnt_d;
            ccd_overrun_q <= ccd_overrun_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------
  logic              cpu_ren, cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              acc_req, acc_we, acc_gnt, acc_rvalid;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, acc_rdata;
  logic              ccd_req, ccd_gnt, ccd_overrun, overrun_clr;
  logic [ADDR_W-1:0] ccd_addr;
  logic [DATA_W-1:0] ccd_wdata;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata = '0;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CCD_MAX_WAIT(8), .WAIT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_ren(cpu_ren), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .acc_rdata(acc_rdata),
    .ccd_req(ccd_req), .ccd_addr(ccd_addr), .ccd_wdata(ccd_wdata),
    .ccd_gnt(ccd_gnt), .ccd_overrun(ccd_overrun), .overrun_clr(overrun_clr),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // Behavioural single-port BRAM with 1-cycle registered read.
  logic [DATA_W-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata     <= mem[bram_addr];
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard counters and helpers
  // ---------------------------------------------------------------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are
  // sampled well away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_idle();
    cpu_ren = 0; cpu_wren = 0; cpu_addr = '0; cpu_wdata = '0;
    acc_req = 0; acc_we = 0; acc_addr = '0; acc_wdata = '0;
    ccd_req = 0; ccd_addr = '0; ccd_wdata = '0;
    overrun_clr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    set_idle();
    rst_n = 0;
    tick(); tick();
    settle();
    check("rst_rvalid",  acc_rvalid, 0);
    check("rst_overrun", ccd_overrun, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_addr", bram_addr, 0);
    rst_n = 1;
    tick();

    // CPU store beats both secondary requests.
    cpu_wren = 1; cpu_addr = 11'h010; cpu_wdata = 16'hBEEF;
    acc_req = 1; acc_we = 0; acc_addr = 11'h100;
    ccd_req = 1; ccd_addr = 11'h200; ccd_wdata = 16'hC0DE;
    settle();
    check("cpu_pri_we",    bram_we, 1);
    check("cpu_pri_en",    bram_en, 1);
    check("cpu_pri_addr",  bram_addr, 11'h010);
    check("cpu_pri_wdata", bram_wdata, 16'hBEEF);
    check("cpu_pri_accg",  acc_gnt, 0);
    check("cpu_pri_ccdg",  ccd_gnt, 0);
    tick();
    acc_req = 0; ccd_req = 0;

    // Preload the acc read targets through the CPU.
    cpu_addr = 11'h100; cpu_wdata = 16'h1111; tick();
    cpu_addr = 11'h101; cpu_wdata = 16'h2222; tick();

    // CPU load with one-cycle return.
    cpu_wren = 0; cpu_ren = 1; cpu_addr = 11'h010;
    settle();
    check("cpu_ld_we", bram_we, 0);
    check("cpu_ld_en", bram_en, 1);
    tick();
    cpu_ren = 0;
    settle();
    check("cpu_ld_data", cpu_rdata, 16'hBEEF);
    check("idle_en", bram_en, 0);
    check("idle_wdata", bram_wdata, 0);

    // Round robin from reset pointer (acc favoured first).
    acc_req = 1; acc_we = 0; acc_addr = 11'h100;
    ccd_req = 1; ccd_addr = 11'h020; ccd_wdata = 16'h5A5A;
    settle();
    check("rr1_accg", acc_gnt, 1);
    check("rr1_ccdg", ccd_gnt, 0);
    check("rr1_addr", bram_addr, 11'h100);
    check("rr1_we",   bram_we, 0);
    tick();
    acc_addr = 11'h101;
    settle();
    check("rr1_rvalid", acc_rvalid, 1);
    check("rr1_rdata",  acc_rdata, 16'h1111);
    check("rr2_ccdg", ccd_gnt, 1);
    check("rr2_accg", acc_gnt, 0);
    check("rr2_we",   bram_we, 1);
    check("rr2_addr", bram_addr, 11'h020);
    check("rr2_wdata", bram_wdata, 16'h5A5A);
    tick();
    ccd_addr = 11'h021; ccd_wdata = 16'h6B6B;
    settle();
    check("rr2_rvalid", acc_rvalid, 0);
    check("rr2_rdata",  acc_rdata, 0);
    check("rr3_accg", acc_gnt, 1);
    check("rr3_addr", bram_addr, 11'h101);
    tick();
    settle();
    check("rr3_rdata", acc_rdata, 16'h2222);
    check("rr4_ccdg", ccd_gnt, 1);
    tick();
    acc_req = 0; ccd_req = 0;

    // Confirm the CCD pixel landed.
    cpu_ren = 1; cpu_addr = 11'h020;
    tick();
    cpu_ren = 0;
    settle();
    check("ccd_wr_data", cpu_rdata, 16'h5A5A);

    // Back-to-back acc reads.
    acc_req = 1; acc_we = 0; acc_addr = 11'h100;
    settle();
    check("b2b1_gnt", acc_gnt, 1);
    tick();
    acc_addr = 11'h101;
    settle();
    check("b2b1_rvalid", acc_rvalid, 1);
    check("b2b1_rdata",  acc_rdata, 16'h1111);
    check("b2b2_gnt", acc_gnt, 1);
    tick();
    acc_req = 0;
    settle();
    check("b2b2_rvalid", acc_rvalid, 1);
    check("b2b2_rdata",  acc_rdata, 16'h2222);
    tick();
    check("b2b_done_rvalid", acc_rvalid, 0);

    // Starvation: CPU loads every cycle while CCD waits.
    cpu_ren = 1; cpu_addr = 11'h010;
    ccd_req = 1; ccd_addr = 11'h022; ccd_wdata = 16'h7777;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("starve_%0d", i), ccd_overrun, 0);
    end
    tick();
    check("starve_8", ccd_overrun, 1);
    cpu_ren = 0;
    settle();
    check("starve_ccdg", ccd_gnt, 1);
    tick();
    ccd_req = 0;
    check("overrun_sticky", ccd_overrun, 1);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    check("overrun_clr", ccd_overrun, 0);

    // Set wins over a coincident clear.
    cpu_ren = 1; ccd_req = 1;
    for (int i = 1; i <= 7; i++) tick();
    overrun_clr = 1;
    tick();
    check("set_beats_clr", ccd_overrun, 1);
    cpu_ren = 0;
    tick();
    ccd_req = 0; overrun_clr = 0;
    check("clr_after_set", ccd_overrun, 0);

    // Cancel: pointer now at CCD; make acc win once so it points at ACC.
    acc_req = 1; acc_we = 0; acc_addr = 11'h101;
    settle();
    check("pre_cancel_gnt", acc_gnt, 1);
    tick();
    check("pre_cancel_rdata", acc_rdata, 16'h2222);
    cpu_ren = 1; cpu_addr = 11'h010; acc_addr = 11'h100;
    settle();
    check("cancel_gnt", acc_gnt, 0);
    check("cancel_addr", bram_addr, 11'h010);
    tick();
    cpu_ren = 0; acc_req = 0;
    settle();
    check("cancel_rvalid", acc_rvalid, 0);
    tick();
    acc_req = 1; ccd_req = 1; ccd_addr = 11'h023; ccd_wdata = 16'h3333;
    settle();
    check("cancel_rr_ccdg", ccd_gnt, 1);
    check("cancel_rr_accg", acc_gnt, 0);
    tick();
    check("cancel_rr_next_accg", acc_gnt, 1);
    tick();
    acc_req = 0; ccd_req = 0;

    // Reset mid-traffic: overrun set and an acc read in flight.
    cpu_ren = 1; ccd_req = 1;
    for (int i = 1; i <= 8; i++) tick();
    check("rst_pre_overrun", ccd_overrun, 1);
    cpu_ren = 0; ccd_req = 0;
    acc_req = 1; acc_we = 0; acc_addr = 11'h100;
    settle();
    check("rst_pre_gnt", acc_gnt, 1);
    rst_n = 0;
    settle();
    check("rst_async_overrun", ccd_overrun, 0);
    tick();
    check("rst_mid_rvalid", acc_rvalid, 0);
    acc_req = 0;
    settle();
    check("rst_mid_bram_en", bram_en, 0);
    rst_n = 1;
    tick();
    // Pointer was at ACC before reset; reset must favour acc again.
    acc_req = 1; ccd_req = 1;
    settle();
    check("rst_rr_accg", acc_gnt, 1);
    check("rst_rr_ccdg", ccd_gnt, 0);
    tick();
    set_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 2K x 16 data BRAM between three requesters: the CPU mem/wb stage, the accelerator weight/activation fetch port, and the CCD/IPU pixel-capture port. The CPU has no stall path, so it always wins the BRAM. The accelerator and CCD ports are round-robin arbitrated on the cycles the CPU leaves idle, using a req/gnt handshake. The block also tracks CCD starvation so software can detect dropped pixels.

Parameters:
ADDR_W, 11, BRAM word address width
DATA_W, 16, BRAM data width
CCD_MAX_WAIT, 8, consecutive denied CCD cycles before overrun flags; legal range 1..255
WAIT_W, 8, width of the per-port wait counters; must hold CCD_MAX_WAIT

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cpu_ren  in  1  CPU load request for this cycle
cpu_wren  in  1  CPU store request for this cycle
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  load data, valid the cycle after cpu_ren
acc_req  in  1  accelerator access request; held until granted
acc_we  in  1  1 = write, 0 = read; qualified by acc_req
acc_addr  in  ADDR_W  accelerator address
acc_wdata  in  DATA_W  accelerator write data
acc_gnt  out  1  access performed this cycle
acc_rvalid  out  1  acc_rdata valid; one cycle after a granted read
acc_rdata  out  DATA_W  accelerator read data
ccd_req  in  1  CCD pixel write request; held until granted
ccd_addr  in  ADDR_W  pixel address
ccd_wdata  in  DATA_W  pixel data
ccd_gnt  out  1  pixel write performed this cycle
ccd_overrun  out  1  sticky flag: CCD was starved for CCD_MAX_WAIT cycles
overrun_clr  in  1  clears ccd_overrun
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_W  BRAM address
bram_wdata  out  DATA_W  BRAM write data
bram_rdata  in  DATA_W  BRAM read data; 1-cycle registered latency

Behaviour:
- Grant logic is combinational. BRAM outputs are driven from the winner in the same cycle (0-cycle grant latency).
- Priority 1, CPU: wins when cpu_ren or cpu_wren is high. If both are high, the access is a write.
  - bram_en=1, bram_we=cpu_wren, address and data taken from the CPU port.
  - acc_gnt=0 and ccd_gnt=0 that cycle.
- Priority 2, secondary ports: when the CPU is idle, acc and ccd arbitrate round-robin via a 1-bit last_winner register.
  - If both request, the port that did not win last is granted.
  - If only one requests, it is granted.
  - last_winner updates only on a secondary grant.
- No request: bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0.
- CCD accesses are always writes (bram_we=1).
- cpu_rdata = bram_rdata, passed through unmodified. The CPU aligns it with its own one-cycle delay.
- Read return:
  - acc_rvalid is a register, set to 1 the cycle after a granted acc read (acc_gnt & ~acc_we), else 0.
  - acc_rdata = bram_rdata when acc_rvalid=1, else 0.
- A requester must hold req, addr and data stable until it sees gnt. Dropping req before gnt is legal and cancels the request, with no side effects.
- The same requester may issue back-to-back grants, e.g. acc reads on consecutive cycles give consecutive rvalid pulses.
- CCD wait counter (WAIT_W bits):
  - Increments each cycle ccd_req=1 and ccd_gnt=0, saturating at all-ones.
  - Clears to 0 on ccd_gnt or when ccd_req=0.
- ccd_overrun:
  - Sets on the cycle the counter transitions to CCD_MAX_WAIT.
  - Clears on overrun_clr.
  - If set and clear occur in the same cycle, set wins.
- Reset (asynchronous, active-low): last_winner=CCD (so acc is favoured first), acc_rvalid=0, wait counter=0, ccd_overrun=0. All combinational outputs follow from the idle inputs.
- Reset mid-read: the pending acc_rvalid is discarded.
- Address and data widths pass straight through; no truncation or arithmetic.

Test Plan:
- Reset: assert rst_n=0 mid-traffic -> acc_rvalid=0, ccd_overrun=0, and bram_en=0 with no inputs active.
- CPU priority: cpu_wren=1 at addr 0x010 with data 0xBEEF, plus acc_req and ccd_req both high -> bram_we=1, bram_addr=0x010, bram_wdata=0xBEEF, acc_gnt=0, ccd_gnt=0.
- CPU load: cpu_ren at addr 0x010 -> cpu_rdata=0xBEEF on the next cycle.
- Round-robin: with the CPU idle, acc (read) and ccd both requesting continuously from reset -> grants alternate acc, ccd, acc, ccd. acc_rvalid pulses one cycle after each acc grant with the correct data.
- Back-to-back acc reads: acc reads at 0x100 then 0x101 on consecutive cycles, with memory preloaded to 0x1111 and 0x2222 -> acc_rvalid high for 2 cycles, acc_rdata 0x1111 then 0x2222.
- Starvation: CPU issues loads every cycle while ccd_req=1, CCD_MAX_WAIT=8 -> ccd_overrun rises on the 8th denied cycle and stays set after the CPU goes idle and ccd is granted. overrun_clr=1 clears it, and it stays set if clr coincides with a new overrun set.
- Cancel: acc_req pulsed for 1 cycle while the CPU is busy, then dropped -> no acc_gnt, no acc_rvalid, last_winner unchanged.
